// File: rtl/sisc_pkg.sv
// Shared encodings for the sisc control sequencer: field widths, opcodes,
// ALU_OP selects and FSM state codes.
package sisc_pkg;

    localparam int unsigned OPC_W  = 4;
    localparam int unsigned STAT_W = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned ST_W   = 3;

    localparam logic [OPC_W-1:0] OP_NOOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_ALU  = 4'h1;
    localparam logic [OPC_W-1:0] OP_LOD  = 4'h2;
    localparam logic [OPC_W-1:0] OP_STR  = 4'h3;
    localparam logic [OPC_W-1:0] OP_BRA  = 4'h4;
    localparam logic [OPC_W-1:0] OP_BRR  = 4'h5;
    localparam logic [OPC_W-1:0] OP_BNE  = 4'h6;
    localparam logic [OPC_W-1:0] OP_BNR  = 4'h7;
    localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

    localparam logic [1:0] ALU_NONE = 2'b00;
    localparam logic [1:0] ALU_RR   = 2'b01;
    localparam logic [1:0] ALU_RI   = 2'b10;
    localparam logic [1:0] ALU_ADDR = 2'b11;

    localparam logic [ST_W-1:0] ST_START     = 3'd0;
    localparam logic [ST_W-1:0] ST_FETCH     = 3'd1;
    localparam logic [ST_W-1:0] ST_DECODE    = 3'd2;
    localparam logic [ST_W-1:0] ST_EXECUTE   = 3'd3;
    localparam logic [ST_W-1:0] ST_MEM       = 3'd4;
    localparam logic [ST_W-1:0] ST_WRITEBACK = 3'd5;
    localparam logic [ST_W-1:0] ST_HALT      = 3'd6;

endpackage

// File: rtl/sisc_br_eval.sv
// Branch condition evaluator: decides taken/relative from opcode, mask and status.
module sisc_br_eval
    import sisc_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode_i,
    input  logic [STAT_W-1:0] mm_i,
    input  logic [STAT_W-1:0] stat_i,
    output logic              taken_o,
    output logic              rel_o
);

    logic hit;

    always_comb begin
        hit     = |(mm_i & stat_i);
        taken_o = 1'b0;
        rel_o   = 1'b0;
        case (opcode_i)
            OP_BRA: taken_o = hit;
            OP_BRR: begin
                taken_o = hit;
                rel_o   = 1'b1;
            end
            OP_BNE: taken_o = !hit;
            OP_BNR: begin
                taken_o = !hit;
                rel_o   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sisc_ctrl_seq.sv
// Multi-cycle control sequencer for the sisc datapath.
// Optional perf counters INSTR_CNT/CYCLE_CNT when SISC_CTRL_PERF_EN is defined.
module sisc_ctrl_seq
    import sisc_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [OPC_W-1:0]  OPCODE,
    input  logic [STAT_W-1:0] MM,
    input  logic [STAT_W-1:0] STAT,
    output logic              IR_LOAD,
    output logic              PC_WRITE,
    output logic              PC_SEL,
    output logic              BR_SEL,
    output logic              PC_RST,
    output logic [1:0]        ALU_OP,
    output logic              STAT_EN,
    output logic              DM_WE,
    output logic              RF_WE,
    output logic              WB_SEL,
    output logic              RD_SEL,
    output logic              HALTED
`ifdef SISC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]  INSTR_CNT,
    output logic [CNT_W-1:0]  CYCLE_CNT
`endif
);

    logic [ST_W-1:0]  state_q, state_d;
    logic [OPC_W-1:0] op_q, op_d;
    logic             imm_q, imm_d;
    logic             br_taken, br_rel;

    sisc_br_eval u_br_eval (
        .opcode_i (OPCODE),
        .mm_i     (MM),
        .stat_i   (STAT),
        .taken_o  (br_taken),
        .rel_o    (br_rel)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_START;
            op_q    <= OP_NOOP;
            imm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
        end
    end

    // Next state and Moore outputs; the branch decision is taken live in DECODE.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        imm_d    = imm_q;
        IR_LOAD  = 1'b0;
        PC_WRITE = 1'b0;
        PC_SEL   = 1'b0;
        BR_SEL   = 1'b0;
        PC_RST   = 1'b0;
        ALU_OP   = ALU_NONE;
        STAT_EN  = 1'b0;
        DM_WE    = 1'b0;
        RF_WE    = 1'b0;
        WB_SEL   = 1'b0;
        RD_SEL   = 1'b0;
        HALTED   = 1'b0;
        case (state_q)
            ST_START: begin
                PC_RST  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                IR_LOAD  = 1'b1;
                PC_WRITE = 1'b1;
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                op_d  = OPCODE;
                imm_d = MM[STAT_W-1];
                if (br_taken) begin
                    PC_WRITE = 1'b1;
                    PC_SEL   = 1'b1;
                    BR_SEL   = br_rel;
                end
                case (OPCODE)
                    OP_ALU, OP_LOD, OP_STR: state_d = ST_EXECUTE;
                    OP_HLT:                 state_d = ST_HALT;
                    default:                state_d = ST_FETCH;
                endcase
            end
            ST_EXECUTE: begin
                if (op_q == OP_ALU) begin
                    ALU_OP  = imm_q ? ALU_RI : ALU_RR;
                    STAT_EN = 1'b1;
                end else begin
                    ALU_OP  = ALU_ADDR;
                end
                state_d = ST_MEM;
            end
            ST_MEM: begin
                if (op_q == OP_STR) begin
                    DM_WE   = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                RF_WE   = 1'b1;
                WB_SEL  = (op_q == OP_LOD);
                RD_SEL  = (op_q == OP_LOD);
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                HALTED  = 1'b1;
            end
            default: state_d = ST_START;
        endcase
    end

`ifdef SISC_CTRL_PERF_EN
    logic [CNT_W-1:0] instr_cnt_q, cycle_cnt_q;
    logic             instr_done;

    // An instruction completes when leaving its last state toward FETCH or HALT.
    assign instr_done = (state_q != ST_START) && (state_q != ST_HALT) &&
                        ((state_d == ST_FETCH) || (state_d == ST_HALT));

    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else if (state_q != ST_HALT) begin
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (instr_done) begin
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign INSTR_CNT = instr_cnt_q;
    assign CYCLE_CNT = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_sisc_ctrl_seq.sv
// Directed bench for sisc_ctrl_seq: walks each instruction class cycle by cycle.
module tb_sisc_ctrl_seq;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] OPCODE = 4'h0;
    logic [3:0] MM = 4'h0;
    logic [3:0] STAT = 4'h0;
    logic       IR_LOAD, PC_WRITE, PC_SEL, BR_SEL, PC_RST;
    logic [1:0] ALU_OP;
    logic       STAT_EN, DM_WE, RF_WE, WB_SEL, RD_SEL, HALTED;
`ifdef SISC_CTRL_PERF_EN
    logic [31:0] INSTR_CNT, CYCLE_CNT;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    sisc_ctrl_seq dut (
        .CLK      (CLK),
        .RST      (RST),
        .OPCODE   (OPCODE),
        .MM       (MM),
        .STAT     (STAT),
        .IR_LOAD  (IR_LOAD),
        .PC_WRITE (PC_WRITE),
        .PC_SEL   (PC_SEL),
        .BR_SEL   (BR_SEL),
        .PC_RST   (PC_RST),
        .ALU_OP   (ALU_OP),
        .STAT_EN  (STAT_EN),
        .DM_WE    (DM_WE),
        .RF_WE    (RF_WE),
        .WB_SEL   (WB_SEL),
        .RD_SEL   (RD_SEL),
        .HALTED   (HALTED)
`ifdef SISC_CTRL_PERF_EN
        ,
        .INSTR_CNT(INSTR_CNT),
        .CYCLE_CNT(CYCLE_CNT)
`endif
    );

    // {IR_LOAD,PC_WRITE,PC_SEL,BR_SEL,PC_RST,ALU_OP,STAT_EN,DM_WE,RF_WE,WB_SEL,RD_SEL,HALTED}
    logic [12:0] obs;
    assign obs = {IR_LOAD, PC_WRITE, PC_SEL, BR_SEL, PC_RST, ALU_OP,
                  STAT_EN, DM_WE, RF_WE, WB_SEL, RD_SEL, HALTED};

    localparam logic [12:0] E_START  = 13'h0100;
    localparam logic [12:0] E_FETCH  = 13'h1800;
    localparam logic [12:0] E_IDLE   = 13'h0000;
    localparam logic [12:0] E_BR_ABS = 13'h0C00;
    localparam logic [12:0] E_BR_REL = 13'h0E00;
    localparam logic [12:0] E_EX_RI  = 13'h00A0;
    localparam logic [12:0] E_EX_RR  = 13'h0060;
    localparam logic [12:0] E_EX_AD  = 13'h00C0;
    localparam logic [12:0] E_MEM_ST = 13'h0010;
    localparam logic [12:0] E_WB_ALU = 13'h0008;
    localparam logic [12:0] E_WB_LOD = 13'h000E;
    localparam logic [12:0] E_HALT   = 13'h0001;

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: outputs observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [12:0] exp);
        chk(tag, exp);
        step();
    endtask

    // Called in the FETCH cycle: present the instruction fields the IR will hold.
    task automatic fetch(input string tag, input logic [3:0] op, input logic [3:0] mm,
                         input logic [3:0] st);
        OPCODE = op;
        MM     = mm;
        STAT   = st;
        cyc({tag, "_fetch"}, E_FETCH);
    endtask

`ifdef SISC_CTRL_PERF_EN
    task automatic chk_cnt(input string tag, input logic [31:0] ic, input logic [31:0] cc);
        checks++;
        assert (INSTR_CNT === ic && CYCLE_CNT === cc) else begin
            errors++;
            $error("FAIL %s: instr/cycle observed %0d/%0d expected %0d/%0d",
                   tag, INSTR_CNT, CYCLE_CNT, ic, cc);
        end
    endtask
`endif

    initial begin
        @(negedge CLK);
        step();
        step();
        chk("reset_hold", E_START);
        RST = 1'b0;
        cyc("start", E_START);

        fetch("alu_imm", 4'h1, 4'h8, 4'h0);
        cyc("alu_imm_decode", E_IDLE);
        cyc("alu_imm_exec", E_EX_RI);
        cyc("alu_imm_mem", E_IDLE);
        cyc("alu_imm_wb", E_WB_ALU);

        fetch("alu_rr", 4'h1, 4'h3, 4'h0);
        cyc("alu_rr_decode", E_IDLE);
        cyc("alu_rr_exec", E_EX_RR);
        cyc("alu_rr_mem", E_IDLE);
        cyc("alu_rr_wb", E_WB_ALU);

        fetch("bra_taken", 4'h4, 4'b0010, 4'b0010);
        cyc("bra_taken_decode", E_BR_ABS);
        fetch("bra_not", 4'h4, 4'b0010, 4'b0000);
        cyc("bra_not_decode", E_IDLE);
        fetch("brr_taken", 4'h5, 4'b1001, 4'b0001);
        cyc("brr_taken_decode", E_BR_REL);
        fetch("bne_taken", 4'h6, 4'b0010, 4'b1101);
        cyc("bne_taken_decode", E_BR_ABS);
        fetch("bnr_not", 4'h7, 4'b0100, 4'b0100);
        cyc("bnr_not_decode", E_IDLE);
        fetch("bnr_taken", 4'h7, 4'b0100, 4'b0000);
        cyc("bnr_taken_decode", E_BR_REL);

        fetch("str", 4'h3, 4'h0, 4'h0);
        cyc("str_decode", E_IDLE);
        cyc("str_exec", E_EX_AD);
        cyc("str_mem", E_MEM_ST);

        fetch("lod", 4'h2, 4'h0, 4'h0);
        cyc("lod_decode", E_IDLE);
        cyc("lod_exec", E_EX_AD);
        cyc("lod_mem", E_IDLE);
        cyc("lod_wb", E_WB_LOD);

        fetch("undef_op", 4'h9, 4'hF, 4'hF);
        cyc("undef_decode", E_IDLE);

        // Reset landing in EXECUTE must abort the ALU op before writeback.
        fetch("alu_abort", 4'h1, 4'h8, 4'h0);
        cyc("alu_abort_decode", E_IDLE);
        chk("alu_abort_exec", E_EX_RI);
        RST = 1'b1;
        step();
        cyc("abort_start0", E_START);
        chk("abort_start1", E_START);
        RST = 1'b0;
        step();

        fetch("hlt", 4'hF, 4'h0, 4'h0);
        cyc("hlt_decode", E_IDLE);
        for (int i = 0; i < 4; i++) cyc("halt_hold", E_HALT);
        OPCODE = 4'h1;
        cyc("halt_ignores_ir", E_HALT);

`ifdef SISC_CTRL_PERF_EN
        RST = 1'b1;
        step();
        chk_cnt("perf_reset", 32'd0, 32'd0);
        RST = 1'b0;
        cyc("perf_start", E_START);
        fetch("perf_noop", 4'h0, 4'h0, 4'h0);
        cyc("perf_noop_decode", E_IDLE);
        chk_cnt("perf_after_noop", 32'd1, 32'd3);
        fetch("perf_alu", 4'h1, 4'h0, 4'h0);
        step();
        step();
        step();
        step();
        fetch("perf_hlt", 4'hF, 4'h0, 4'h0);
        cyc("perf_hlt_decode", E_IDLE);
        chk_cnt("perf_halt", 32'd3, 32'd10);
        step();
        step();
        chk_cnt("perf_frozen", 32'd3, 32'd10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
